// File: rtl/wb_hb_bridge.sv
// Asynchronous host bus (cs/oe/we strobes) to Wishbone classic master bridge.
// Host strobes are resynchronised; each host access becomes exactly one Wishbone cycle.
module wb_hb_bridge #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hb_cs,
   input  logic                  hb_oe,
   input  logic                  hb_we,
   input  logic [ADDR_WIDTH-1:0] hb_addr,
   inout  wire  [DATA_WIDTH-1:0] hb_data,
   output logic                  hb_rdy,
   output logic                  hb_err,
   output logic                  wb_cyc,
   output logic                  wb_stb,
   output logic                  wb_we,
   output logic [ADDR_WIDTH-1:0] wb_adr,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   input  logic                  wb_ack,
   input  logic                  wb_err
);

   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] oe_sync;
   logic [SYNC_STAGES-1:0] we_sync;
   logic                   cs_s;
   logic                   oe_s;
   logic                   we_s;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic [CNT_W-1:0]       tmo_cnt;
   logic                   tmo_hit;
   logic                   drive;

   // Synchronisers idle high so a held-low strobe is seen as a fresh request after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_sync <= '1;
         oe_sync <= '1;
         we_sync <= '1;
      end else begin
         cs_sync <= {cs_sync[SYNC_STAGES-2:0], hb_cs};
         oe_sync <= {oe_sync[SYNC_STAGES-2:0], hb_oe};
         we_sync <= {we_sync[SYNC_STAGES-2:0], hb_we};
      end
   end

   assign cs_s = cs_sync[SYNC_STAGES-1];
   assign oe_s = oe_sync[SYNC_STAGES-1];
   assign we_s = we_sync[SYNC_STAGES-1];

   always_comb begin
      tmo_hit = 1'b0;
      if (TIMEOUT > 0) tmo_hit = (tmo_cnt == CNT_LAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wb_cyc   <= 1'b0;
         wb_stb   <= 1'b0;
         wb_we    <= 1'b0;
         wb_adr   <= '0;
         wb_dat_o <= '0;
         hb_rdy   <= 1'b0;
         hb_err   <= 1'b0;
         rd_data  <= '0;
         tmo_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!cs_s && (!oe_s || !we_s)) begin
                  state    <= BUS;
                  wb_cyc   <= 1'b1;
                  wb_stb   <= 1'b1;
                  wb_we    <= !we_s;
                  wb_adr   <= hb_addr;
                  wb_dat_o <= hb_data;
                  tmo_cnt  <= '0;
               end
            end
            BUS: begin
               // Error outranks ack, which outranks the timeout.
               if (wb_err) begin
                  state  <= DONE;
                  wb_cyc <= 1'b0;
                  wb_stb <= 1'b0;
                  hb_rdy <= 1'b1;
                  hb_err <= 1'b1;
               end else if (wb_ack) begin
                  state  <= DONE;
                  wb_cyc <= 1'b0;
                  wb_stb <= 1'b0;
                  hb_rdy <= 1'b1;
                  hb_err <= 1'b0;
                  if (!wb_we) rd_data <= wb_dat_i;
               end else if (tmo_hit) begin
                  state  <= DONE;
                  wb_cyc <= 1'b0;
                  wb_stb <= 1'b0;
                  hb_rdy <= 1'b1;
                  hb_err <= 1'b1;
               end else if (TIMEOUT > 0) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            DONE: begin
               if (cs_s) begin
                  state  <= IDLE;
                  hb_rdy <= 1'b0;
                  hb_err <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output enable uses the raw pins so the bus turns around as soon as the host deasserts.
   assign drive   = (state == DONE) && !wb_we && !hb_err && !hb_cs && !hb_oe;
   assign hb_data = drive ? rd_data : 'z;

endmodule

// File: tb/tb_wb_hb_bridge.sv
// Self-checking bench for wb_hb_bridge: directed scenarios plus randomised accesses
// checked against a transaction-level model of the host/Wishbone protocol.
module tb_wb_hb_bridge;

   localparam int unsigned DW   = 16;
   localparam int unsigned AW   = 16;
   localparam int unsigned SYNC = 2;
   localparam int unsigned TMO  = 8;

   logic          clk;
   logic          rst;
   logic          hb_cs;
   logic          hb_oe;
   logic          hb_we;
   logic [AW-1:0] hb_addr;
   tri1  [DW-1:0] hb_data;
   logic [DW-1:0] host_dat;
   logic          host_drv;
   logic          hb_rdy;
   logic          hb_err;
   logic          wb_cyc;
   logic          wb_stb;
   logic          wb_we;
   logic [AW-1:0] wb_adr;
   logic [DW-1:0] wb_dat_o;
   logic [DW-1:0] wb_dat_i;
   logic          wb_ack;
   logic          wb_err;

   int checks;
   int fails;
   int cyc_starts;
   logic [DW-1:0] exp_rd;

   assign hb_data = host_drv ? host_dat : 'z;

   wb_hb_bridge #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .SYNC_STAGES(SYNC),
      .TIMEOUT    (TMO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .hb_cs   (hb_cs),
      .hb_oe   (hb_oe),
      .hb_we   (hb_we),
      .hb_addr (hb_addr),
      .hb_data (hb_data),
      .hb_rdy  (hb_rdy),
      .hb_err  (hb_err),
      .wb_cyc  (wb_cyc),
      .wb_stb  (wb_stb),
      .wb_we   (wb_we),
      .wb_adr  (wb_adr),
      .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i),
      .wb_ack  (wb_ack),
      .wb_err  (wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge wb_cyc) cyc_starts++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_release();
      hb_cs    = 1'b1;
      hb_oe    = 1'b1;
      hb_we    = 1'b1;
      host_drv = 1'b0;
   endtask

   task automatic wait_stb(output int edges);
      edges = 0;
      while (!wb_stb && edges < 20) begin
         tick();
         edges++;
      end
   endtask

   task automatic wait_rdy_low(output int edges);
      edges = 0;
      while (hb_rdy && edges < 20) begin
         tick();
         edges++;
      end
   endtask

   // resp: 0 ack, 1 err, 2 ack+err together, 3 no response (timeout)
   task automatic run_access(input bit is_write, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input int delay, input int resp);
      int n;
      int bus_clks;
      int cyc0;
      logic [DW-1:0] exp_hb;
      cyc0    = cyc_starts;
      hb_addr = addr;
      if (is_write) begin
         host_dat = data;
         host_drv = 1'b1;
         hb_we    = 1'b0;
      end else begin
         hb_oe = 1'b0;
      end
      hb_cs = 1'b0;
      wait_stb(n);
      checks++;
      if (n !== SYNC + 1) begin
         fails++;
         $display("FAIL start_latency: got %0d edges, want %0d", n, SYNC + 1);
      end
      checks++;
      if (wb_we !== is_write || wb_adr !== addr || wb_cyc !== 1'b1) begin
         fails++;
         $display("FAIL bus_setup: we=%b adr=%h cyc=%b, want we=%b adr=%h cyc=1", wb_we, wb_adr, wb_cyc, is_write, addr);
      end
      if (is_write) begin
         checks++;
         if (wb_dat_o !== data) begin
            fails++;
            $display("FAIL write_data: got %h want %h", wb_dat_o, data);
         end
      end
      hb_addr  = ~addr;
      host_dat = ~data;
      if (resp == 3) begin
         bus_clks = 1;
         while (wb_stb && bus_clks < 40) begin
            tick();
            if (wb_stb) bus_clks++;
         end
         checks++;
         if (bus_clks !== int'(TMO)) begin
            fails++;
            $display("FAIL timeout_len: stb high %0d clocks, want %0d", bus_clks, TMO);
         end
      end else begin
         repeat (delay) tick();
         checks++;
         if (wb_stb !== 1'b1 || wb_adr !== addr || wb_we !== is_write) begin
            fails++;
            $display("FAIL bus_hold: stb=%b adr=%h we=%b, want stb=1 adr=%h we=%b", wb_stb, wb_adr, wb_we, addr, is_write);
         end
         wb_ack   = (resp != 1);
         wb_err   = (resp != 0);
         wb_dat_i = data;
         tick();
         wb_ack   = 1'b0;
         wb_err   = 1'b0;
         wb_dat_i = DW'($urandom);
      end
      if (!is_write && resp == 0) exp_rd = data;
      checks++;
      if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || hb_rdy !== 1'b1 || hb_err !== (resp != 0)) begin
         fails++;
         $display("FAIL completion: cyc=%b stb=%b rdy=%b err=%b, want 0 0 1 %b", wb_cyc, wb_stb, hb_rdy, hb_err, resp != 0);
      end
      checks++;
      if (dut.rd_data !== exp_rd) begin
         fails++;
         $display("FAIL read_reg: got %h want %h", dut.rd_data, exp_rd);
      end
      if (!is_write) begin
         exp_hb = (resp == 0) ? data : '1;
         checks++;
         if (hb_data !== exp_hb) begin
            fails++;
            $display("FAIL hb_data_read: got %h want %h", hb_data, exp_hb);
         end
      end
      tick();
      tick();
      checks++;
      if (hb_rdy !== 1'b1 || hb_err !== (resp != 0)) begin
         fails++;
         $display("FAIL done_hold: rdy=%b err=%b, want 1 %b", hb_rdy, hb_err, resp != 0);
      end
      if (!is_write && resp == 0) begin
         hb_oe = 1'b1;
         #1;
         checks++;
         if (hb_data !== '1) begin
            fails++;
            $display("FAIL hb_data_release: got %h want high-Z (pulled %h)", hb_data, {DW{1'b1}});
         end
      end
      host_release();
      wait_rdy_low(n);
      checks++;
      if (n !== SYNC + 1 || hb_err !== 1'b0) begin
         fails++;
         $display("FAIL done_exit: %0d edges err=%b, want %0d edges err=0", n, hb_err, SYNC + 1);
      end
      checks++;
      if (cyc_starts !== cyc0 + 1) begin
         fails++;
         $display("FAIL cycle_count: got %0d want %0d", cyc_starts - cyc0, 1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      host_release();
      hb_addr  = 16'h5A5A;
      host_dat = '0;
      wb_dat_i = '0;
      wb_ack   = 1'b0;
      wb_err   = 1'b0;
      exp_rd   = '0;
      tick();
      tick();
      checks++;
      if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0 || hb_rdy !== 1'b0 || hb_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: cyc=%b stb=%b we=%b rdy=%b err=%b, want all 0", wb_cyc, wb_stb, wb_we, hb_rdy, hb_err);
      end
      checks++;
      if (wb_adr !== '0 || wb_dat_o !== '0 || dut.rd_data !== '0) begin
         fails++;
         $display("FAIL reset_regs: adr=%h dat_o=%h rd=%h, want 0", wb_adr, wb_dat_o, dut.rd_data);
      end
      checks++;
      if (hb_data !== '1) begin
         fails++;
         $display("FAIL reset_hb_data: got %h want high-Z", hb_data);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_write();
      run_access(1'b1, 16'h0012, 16'hBEEF, 3, 0);
   endtask

   task automatic test_read();
      run_access(1'b0, 16'h00A0, 16'h1234, 2, 0);
   endtask

   task automatic test_timeout();
      run_access(1'b0, 16'h0100, 16'h4321, 0, 3);
      run_access(1'b1, 16'h0104, 16'h0F0F, 0, 3);
   endtask

   task automatic test_error();
      run_access(1'b0, 16'h0055, 16'hDEAD, 1, 2);
      run_access(1'b0, 16'h0056, 16'hCAFE, 0, 1);
   endtask

   task automatic test_reset_mid_bus();
      int n;
      int cyc0;
      cyc0     = cyc_starts;
      hb_addr  = 16'h0300;
      host_dat = 16'h7777;
      host_drv = 1'b1;
      hb_we    = 1'b0;
      hb_cs    = 1'b0;
      wait_stb(n);
      tick();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || hb_rdy !== 1'b0) begin
         fails++;
         $display("FAIL reset_async: cyc=%b stb=%b rdy=%b, want 0 0 0", wb_cyc, wb_stb, hb_rdy);
      end
      @(negedge clk);
      rst = 1'b1;
      wait_stb(n);
      checks++;
      if (n !== SYNC + 1 || cyc_starts !== cyc0 + 2) begin
         fails++;
         $display("FAIL reset_restart: %0d edges, %0d cycles, want %0d edges, 2 cycles", n, cyc_starts - cyc0, SYNC + 1);
      end
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
      checks++;
      if (hb_rdy !== 1'b1 || hb_err !== 1'b0 || wb_dat_o !== 16'h7777) begin
         fails++;
         $display("FAIL reset_complete: rdy=%b err=%b dat_o=%h, want 1 0 7777", hb_rdy, hb_err, wb_dat_o);
      end
      host_release();
      wait_rdy_low(n);
   endtask

   task automatic test_back_to_back();
      int n;
      int cyc0;
      logic [DW-1:0] rdat;
      cyc0    = cyc_starts;
      rdat    = 16'h0A5C;
      hb_addr = 16'h0040;
      hb_cs   = 1'b0;
      hb_oe   = 1'b0;
      wait_stb(n);
      wb_dat_i = rdat;
      wb_ack   = 1'b1;
      tick();
      wb_ack = 1'b0;
      exp_rd = rdat;
      hb_oe  = 1'b1;
      tick();
      tick();
      hb_oe = 1'b0;
      repeat (6) tick();
      checks++;
      if (cyc_starts !== cyc0 + 1 || wb_stb !== 1'b0 || hb_rdy !== 1'b1) begin
         fails++;
         $display("FAIL b2b_single: cycles=%0d stb=%b rdy=%b, want 1 0 1", cyc_starts - cyc0, wb_stb, hb_rdy);
      end
      checks++;
      if (hb_data !== rdat) begin
         fails++;
         $display("FAIL b2b_redrive: got %h want %h", hb_data, rdat);
      end
      host_release();
      wait_rdy_low(n);
      hb_cs = 1'b0;
      hb_oe = 1'b0;
      wait_stb(n);
      checks++;
      if (n !== SYNC + 1 || cyc_starts !== cyc0 + 2) begin
         fails++;
         $display("FAIL b2b_second: %0d edges, %0d cycles, want %0d edges, 2 cycles", n, cyc_starts - cyc0, SYNC + 1);
      end
      wb_dat_i = 16'h1111;
      wb_ack   = 1'b1;
      tick();
      wb_ack = 1'b0;
      exp_rd = 16'h1111;
      host_release();
      wait_rdy_low(n);
   endtask

   task automatic test_cs_release();
      int n;
      hb_addr  = 16'h0777;
      host_dat = 16'h2468;
      host_drv = 1'b1;
      hb_we    = 1'b0;
      hb_cs    = 1'b0;
      wait_stb(n);
      host_release();
      repeat (3) tick();
      checks++;
      if (wb_stb !== 1'b1 || wb_cyc !== 1'b1) begin
         fails++;
         $display("FAIL cs_release_abort: stb=%b cyc=%b, want 1 1", wb_stb, wb_cyc);
      end
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
      checks++;
      if (hb_rdy !== 1'b1 || wb_cyc !== 1'b0) begin
         fails++;
         $display("FAIL cs_release_done: rdy=%b cyc=%b, want 1 0", hb_rdy, wb_cyc);
      end
      tick();
      checks++;
      if (hb_rdy !== 1'b0) begin
         fails++;
         $display("FAIL cs_release_exit: rdy=%b want 0", hb_rdy);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] d;
      for (int i = 0; i < 10; i++) begin
         d = DW'($urandom_range(0, 16'hFFFE));
         run_access(1'($urandom), AW'($urandom), d, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      checks     = 0;
      fails      = 0;
      cyc_starts = 0;
      host_drv   = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_error();
      test_reset_mid_bus();
      test_back_to_back();
      test_cs_release();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/wb_hb_bridge.md
WB_HB_BRIDGE -- requirements
Module: wb_hb_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, host and Wishbone data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, host and Wishbone address width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2 (min 2), synchroniser depth on hb_cs/hb_oe/hb_we.
REQ-004 SHALL have parameter TIMEOUT, default 255, the Wishbone cycle limit in clocks; 0 disables the timeout.
REQ-005 Ports, in order:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- hb_cs  in  1  host chip select, active-low.
- hb_oe  in  1  host output enable (read), active-low.
- hb_we  in  1  host write enable, active-low.
- hb_addr  in  ADDR_WIDTH  host address.
- hb_data  inout  DATA_WIDTH  host data, tristate.
- hb_rdy  out  1  access complete, active-high.
- hb_err  out  1  access failed (wb_err or timeout), valid while hb_rdy=1.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_we  out  1  Wishbone write.
- wb_adr  out  ADDR_WIDTH  Wishbone address.
- wb_dat_o  out  DATA_WIDTH  Wishbone write data.
- wb_dat_i  in  DATA_WIDTH  Wishbone read data.
- wb_ack  in  1  Wishbone acknowledge.
- wb_err  in  1  Wishbone error.

Function
REQ-006 hb_cs, hb_oe and hb_we SHALL each pass through a SYNC_STAGES flop chain; the FSM SHALL use only the synchronised copies (cs_s, oe_s, we_s).
REQ-007 The FSM SHALL have exactly three states: IDLE, BUS, DONE.
REQ-008 In IDLE, when cs_s=0 and (oe_s=0 or we_s=0), the FSM SHALL enter BUS on the next edge.
- On that edge it SHALL capture hb_addr into wb_adr and hb_data into wb_dat_o.
- It SHALL set wb_we = !we_s.
REQ-009 When oe_s and we_s are both 0 at start, the access SHALL be a write.
REQ-010 In BUS, wb_cyc and wb_stb SHALL be 1, all from registers; wb_adr, wb_dat_o and wb_we SHALL be stable for the whole state.
REQ-011 In BUS, on wb_ack=1 the FSM SHALL, on the same edge:
- clear wb_cyc and wb_stb;
- enter DONE with hb_rdy=1 and hb_err=0;
- if the access is a read, capture wb_dat_i into the read-data register.
REQ-012 In BUS, on wb_err=1 the FSM SHALL go to DONE with hb_rdy=1 and hb_err=1; the read-data register SHALL NOT be updated.
REQ-013 If wb_ack and wb_err are both 1, wb_err SHALL take precedence.
REQ-014 When TIMEOUT>0, a counter SHALL run in BUS, cleared on BUS entry. When it reaches TIMEOUT-1 with no ack/err, the FSM SHALL:
- drop wb_cyc/wb_stb;
- go to DONE with hb_rdy=1, hb_err=1.
Counter width SHALL be $clog2(TIMEOUT+1).
REQ-015 Minimum latency from synchronised request to wb_stb=1 SHALL be 1 clock; from wb_ack sampled to hb_rdy=1 SHALL be 1 clock.
REQ-016 In DONE, hb_rdy and hb_err SHALL hold until cs_s=1. The FSM SHALL then return to IDLE, clearing hb_rdy and hb_err on the same edge.
REQ-017 A new access SHALL NOT start without returning through IDLE; hb_addr/hb_data changes during BUS or DONE SHALL be ignored.
REQ-018 If cs_s returns to 1 during BUS, the Wishbone cycle SHALL still complete normally (no abort); DONE SHALL then exit on the next edge.
REQ-019 hb_data SHALL be driven with the read-data register only when all of the following hold (combinational output enable on the raw pins):
- state is DONE;
- the access is a read with hb_err=0;
- hb_cs=0 and hb_oe=0.
Otherwise hb_data SHALL be high-Z.

Reset
REQ-020 While rst=0, asynchronously and regardless of clock:
- state=IDLE;
- wb_cyc=wb_stb=wb_we=0;
- wb_adr=0, wb_dat_o=0;
- hb_rdy=0, hb_err=0;
- read-data register=0, timeout counter=0;
- synchroniser flops=1;
- hb_data high-Z.
REQ-021 Reset asserted mid-BUS SHALL drop wb_cyc/wb_stb immediately; after release the FSM SHALL wait in IDLE for a fresh request.

Verification
REQ-022 Write: hb_addr=0x0012, hb_data=0xBEEF, cs=we=0; ack after 3 clocks -> one wb cycle, wb_we=1, wb_adr=0x0012, wb_dat_o=0xBEEF; hb_rdy=1, hb_err=0 until cs=1.
REQ-023 Read: hb_addr=0x00A0, cs=oe=0; wb_dat_i=0x1234 with ack -> hb_data=0x1234 while cs=oe=0; high-Z after oe=1.
REQ-024 Timeout: TIMEOUT=8, no ack -> wb_stb drops after exactly 8 BUS clocks; hb_rdy=1, hb_err=1, hb_data stays high-Z.
REQ-025 Error: ack=1 and err=1 on the same clock of a read -> hb_err=1, read-data register unchanged.
REQ-026 Reset at BUS clock 2 -> wb_cyc=0 before the next edge; a held request after release starts a new cycle only after resync.
REQ-027 Back-to-back: cs held low across two oe pulses -> only one wb cycle; a second cycle occurs only after cs=1 then 0.
